// File: rtl/jk_bank_ctrl.sv
// Two-requester round-robin controller that drives a bank of JK cells.
// Define JK_BANK_CTRL_CHECK_EN to add the CHECK state with readback comparison.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] mask0,
  input  logic [WIDTH-1:0] mask1,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StAck} state_e;

  state_e           state_q, state_d;
  logic             win_q, win_d;   // requester owning the current operation
  logic             last_q, last_d; // requester served most recently
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             pick;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  assign pick = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cmd_q   <= 2'b00;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d = StDrive;
          win_d   = pick;
          last_d  = pick;
          cmd_d   = pick ? cmd1 : cmd0;
          mask_d  = pick ? mask1 : mask0;
        end
      end
`ifdef JK_BANK_CTRL_CHECK_EN
      StDrive: state_d = StCheck;
`else
      StDrive: state_d = StAck;
`endif
      StCheck: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    J    = '0;
    K    = '0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    if (state_q == StDrive) begin
      J = mask_q & {WIDTH{cmd_q[1]}};
      K = mask_q & {WIDTH{cmd_q[0]}};
    end
    if (state_q == StAck) begin
      ack0 = ~win_q;
      ack1 = win_q;
    end
  end

  // Grant spans DRIVE through ACK and is decoded purely from flops.
  assign gnt0 = (state_q != StIdle) & ~win_q;
  assign gnt1 = (state_q != StIdle) & win_q;

`ifdef JK_BANK_CTRL_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             mis_q;

  function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       cmd,
                                                input logic [WIDTH-1:0] mask);
    logic [WIDTH-1:0] res;
    unique case (cmd)
      2'b00:   res = cur;
      2'b01:   res = cur & ~mask;
      2'b10:   res = cur | mask;
      default: res = cur ^ mask;
    endcase
    return res;
  endfunction

  // Expected value is taken from q before the bank applies the DRIVE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (state_q == StDrive) exp_q <= predict(q, cmd_q, mask_q);
      if (state_q == StCheck) mis_q <= (q != exp_q);
    end
  end

  assign err = (state_q == StAck) & mis_q;
`else
  logic unused_q;
  assign unused_q = ^q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized bench for jk_bank_ctrl with a JK bank plant and a transaction-level model.
module tb_jk_bank_ctrl;
  localparam int unsigned W = 8;
`ifdef JK_BANK_CTRL_CHECK_EN
  localparam int Lat = 3;
  localparam bit ChkEn = 1'b1;
`else
  localparam int Lat = 2;
  localparam bit ChkEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [1:0]   cmd0, cmd1;
  logic [W-1:0] mask0, mask1;
  logic [W-1:0] q, J, K;
  logic         gnt0, gnt1, ack0, ack1, err;

  logic         bank_load, stuck;
  logic [W-1:0] bank_val;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           last_served;
  logic [W-1:0] model_q;

  always #5 clk = ~clk;

  jk_bank_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .req0 (req0),
    .req1 (req1),
    .cmd0 (cmd0),
    .cmd1 (cmd1),
    .mask0(mask0),
    .mask1(mask1),
    .q    (q),
    .J    (J),
    .K    (K),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .ack0 (ack0),
    .ack1 (ack1),
    .err  (err)
  );

  // Bank plant: classic JK characteristic equation, optionally stuck.
  always_ff @(posedge clk) begin
    if (bank_load) q <= bank_val;
    else if (!stuck) q <= (J & ~q) | (~K & q);
  end

  function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] v, input logic [1:0] c,
                                              input logic [W-1:0] m);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < W; i++) begin
      if (m[i]) begin
        if (c == 2'd1) r[i] = 1'b0;
        else if (c == 2'd2) r[i] = 1'b1;
        else if (c == 2'd3) r[i] = ~v[i];
      end
    end
    return r;
  endfunction

  task automatic set_bank(input logic [W-1:0] v);
    bank_val  = v;
    bank_load = 1'b1;
    @(posedge clk); #1;
    bank_load = 1'b0;
    model_q   = v;
  endtask

  // One complete operation from an idle controller, checked every cycle.
  task automatic op(input bit r0, input bit r1, input logic [1:0] c0, input logic [1:0] c1,
                    input logic [W-1:0] m0, input logic [W-1:0] m1, input bit drop,
                    input bit keep, output int win);
    logic [1:0]     c;
    logic [W-1:0]   m, ideal;
    logic [2*W-1:0] ejk, ajk;
    logic [1:0]     eg;
    logic [2:0]     eae;
    bit             eerr;
    win = (r0 && r1) ? ((last_served == 0) ? 1 : 0) : (r0 ? 0 : 1);
    last_served = win;
    c     = (win == 1) ? c1 : c0;
    m     = (win == 1) ? m1 : m0;
    ideal = apply_cmd(model_q, c, m);
    ejk   = {(c[1] ? m : {W{1'b0}}), (c[0] ? m : {W{1'b0}})};
    eg    = (win == 0) ? 2'b10 : 2'b01;
    eerr  = ChkEn && stuck && (ideal != model_q);
    if (!stuck) model_q = ideal;
    req0 = r0; req1 = r1; cmd0 = c0; cmd1 = c1; mask0 = m0; mask1 = m1;
    @(posedge clk); #1;
    if (drop) begin
      if (win == 0) req0 = 1'b0;
      else req1 = 1'b0;
      cmd0 = 2'($urandom); cmd1 = 2'($urandom);
      mask0 = W'($urandom); mask1 = W'($urandom);
    end
    for (int k = 1; k <= Lat; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1} !== eg) begin
        n_bad++;
        $display("FAIL gnt cyc=%0d: got %b want %b", k, {gnt0, gnt1}, eg);
      end
      ajk = {J, K};
      n_cmp++;
      if (ajk !== ((k == 1) ? ejk : {2*W{1'b0}})) begin
        n_bad++;
        $display("FAIL jk cyc=%0d: got %h want %h", k, ajk, (k == 1) ? ejk : {2*W{1'b0}});
      end
      eae = (k == Lat) ? {win == 0, win == 1, eerr} : 3'b000;
      n_cmp++;
      if ({ack0, ack1, err} !== eae) begin
        n_bad++;
        $display("FAIL ack_err cyc=%0d: got %b want %b", k, {ack0, ack1, err}, eae);
      end
      @(posedge clk); #1;
    end
    if (!keep) begin
      req0 = 1'b0; req1 = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, ack0, ack1, err, J, K} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_op: got %b want 0", {gnt0, gnt1, ack0, ack1, err, J, K});
    end
    n_cmp++;
    if (q !== model_q) begin
      n_bad++;
      $display("FAIL bank: got %h want %h", q, model_q);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b11; cmd1 = 2'b10; mask0 = '1; mask1 = '1;
    set_bank(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1, ack0, ack1, err, J, K} !== '0) begin
        n_bad++;
        $display("FAIL reset_outs: got %b want 0", {gnt0, gnt1, ack0, ack1, err, J, K});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    last_served = 1;
  endtask

  task automatic test_latency();
    int w;
    set_bank(8'h00);
    op(1'b1, 1'b0, 2'b10, 2'b00, 8'h0F, 8'h00, 1'b0, 1'b0, w);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL latency_winner: got %0d want 0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int exp_order[4] = '{0, 1, 0, 1};
    req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b11; cmd1 = 2'b11; mask0 = 8'hFF; mask1 = 8'h01;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_served = 1;
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b1, 2'b11, 2'b11, 8'hFF, 8'h01, 1'b0, 1'b1, w);
      n_cmp++;
      if (w !== exp_order[i]) begin
        n_bad++;
        $display("FAIL b2b_order op=%0d: got %0d want %0d", i, w, exp_order[i]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_readback_err();
    int w;
    set_bank(8'hAA);
    stuck = 1'b1;
    op(1'b1, 1'b0, 2'b01, 2'b00, 8'hFF, 8'h00, 1'b0, 1'b0, w);
    stuck = 1'b0;
    op(1'b1, 1'b0, 2'b10, 2'b00, 8'h0F, 8'h00, 1'b0, 1'b0, w);
  endtask

  task automatic test_reset_mid_op();
    int           w;
    logic [W-1:0] ideal;
    set_bank(8'h5A);
    w     = (last_served == 0) ? 1 : 0;
    ideal = apply_cmd(model_q, 2'b11, (w == 1) ? 8'h0F : 8'hF0);
    req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b11; cmd1 = 2'b11; mask0 = 8'hF0; mask1 = 8'h0F;
    @(posedge clk); #1;
`ifdef JK_BANK_CTRL_CHECK_EN
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_ack_drive: got %b want 00", {ack0, ack1});
    end
    @(posedge clk); #1;
`endif
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_ack_pre: got %b want 00", {ack0, ack1});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    model_q = ideal;
    last_served = 1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, ack0, ack1, err, J, K} !== '0) begin
      n_bad++;
      $display("FAIL abort_outs: got %b want 0", {gnt0, gnt1, ack0, ack1, err, J, K});
    end
    n_cmp++;
    if (q !== model_q) begin
      n_bad++;
      $display("FAIL abort_bank: got %h want %h", q, model_q);
    end
    op(1'b1, 1'b1, 2'b10, 2'b01, 8'h11, 8'h22, 1'b0, 1'b0, w);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL abort_tie: got %0d want 0", w);
    end
  endtask

  task automatic test_null_ops();
    int w;
    set_bank(8'hC3);
    op(1'b1, 1'b0, 2'b00, 2'b00, 8'hFF, 8'h00, 1'b0, 1'b0, w);
    op(1'b0, 1'b1, 2'b00, 2'b11, 8'h00, 8'h00, 1'b0, 1'b0, w);
    op(1'b1, 1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, w);
  endtask

  task automatic test_random();
    int          w;
    logic [1:0]  r;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) set_bank(W'($urandom));
      stuck = ($urandom_range(0, 5) == 0);
      r = 2'($urandom_range(1, 3));
      op(r[0], r[1], 2'($urandom), 2'($urandom), W'($urandom), W'($urandom),
         ($urandom_range(0, 3) == 0), 1'b0, w);
      stuck = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0; mask0 = '0; mask1 = '0;
    bank_load = 1'b0; stuck = 1'b0; bank_val = '0; last_served = 1; model_q = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_readback_err();
    test_reset_mid_op();
    test_null_ops();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
